// File: rtl/addsub_acc_unit_if.sv
// Operand/result handshake bundle for addsub_acc_unit.
// The slave side is the unit itself. The master side is the operand source
// together with the result consumer.
interface addsub_acc_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] n;
  logic [1:0]       op;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             co;
  logic             ovf;
  logic [CNT_W-1:0] op_cnt;

  modport slave (
    input  in_valid, x, n, op, clr, out_ready,
    output in_ready, out_valid, f, co, ovf, op_cnt
  );

  modport master (
    output in_valid, x, n, op, clr, out_ready,
    input  in_ready, out_valid, f, co, ovf, op_cnt
  );
endinterface

// File: rtl/addsub_acc_unit.sv
// Registered add/subtract unit with an accumulator and valid/ready on both sides.
// F = A +/- B. The direction comes from the op code, or from x[0] in legacy
// and accumulate modes. The unit keeps a one-deep output register and a
// saturating count of accepted beats.
module addsub_acc_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_acc_unit_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             co;
    logic             ovf;
  } res_t;

  localparam logic [WIDTH-1:0] LO_CIN_PAD = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             in_ready;
  logic             accept;
  logic             is_acc;
  logic             is_sub;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] lo_sum;
  logic             c_msb;
  logic [1:0]       hi_sum;
  res_t             res_d, res_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] op_cnt_d, op_cnt_q;

  // A new beat can enter when the output slot is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Operand selection and a split adder.
  // The low WIDTH-1 bits give the carry into the MSB. The MSB stage gives the
  // carry out. Overflow is the XOR of those two carries.
  always_comb begin
    is_acc = (bus.op == 2'b11);
    is_sub = (bus.op == 2'b10) || (((bus.op == 2'b00) || is_acc) && bus.x[0]);
    a_op   = is_acc ? (bus.clr ? '0 : acc_q) : bus.x;
    b_op   = is_sub ? ~bus.n : bus.n;
    lo_sum = {1'b0, a_op[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
           + {LO_CIN_PAD[WIDTH-1:1], is_sub};
    c_msb  = lo_sum[WIDTH-1];
    hi_sum = {1'b0, a_op[WIDTH-1]} + {1'b0, b_op[WIDTH-1]} + {1'b0, c_msb};
    res_d.f   = {hi_sum[0], lo_sum[WIDTH-2:0]};
    res_d.co  = hi_sum[1];
    res_d.ovf = hi_sum[1] ^ c_msb;
  end

  // Next state for the output slot, the accumulator and the saturating counter.
  always_comb begin
    out_valid_d = accept || (out_valid_q && !bus.out_ready);
    acc_d       = acc_q;
    op_cnt_d    = op_cnt_q;
    if (accept && is_acc) begin
      acc_d = res_d.f;  // when clr is also set, a_op was already forced to zero
    end else if (bus.clr) begin
      acc_d = '0;
    end
    if (accept && (op_cnt_q != CNT_MAX)) begin
      op_cnt_d = op_cnt_q + CNT_ONE;
    end
  end

  // State registers. The result is loaded only on accept, so it holds while
  // the consumer stalls and also after the result is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      op_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      op_cnt_q    <= op_cnt_d;
      if (accept) res_q <= res_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = res_q.f;
  assign bus.co        = res_q.co;
  assign bus.ovf       = res_q.ovf;
  assign bus.op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Bench for addsub_acc_unit.
// A cycle-level reference model computes each result with plain signed and
// unsigned integer arithmetic. A second instance with CNT_W=4 exercises
// counter saturation.
module tb_addsub_acc_unit;

  logic clk;
  logic rst_n;

  addsub_acc_unit_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  addsub_acc_unit_if #(.WIDTH(8), .CNT_W(4))  bus1 ();

  addsub_acc_unit #(.WIDTH(8), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  addsub_acc_unit #(.WIDTH(8), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  bit m_vld;
  int m_f;
  bit m_co, m_ovf;
  int m_acc;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result of one operation, derived from plain integer arithmetic.
  task automatic model_calc(input bit [1:0] o, input int xx, input int nn, input bit c,
                            output int f, output bit co, output bit ovf);
    bit sub;
    int a, sa, sn, full, r;
    sub = (o == 2) || (((o == 0) || (o == 3)) && (xx % 2 == 1));
    a   = (o == 3) ? (c ? 0 : m_acc) : xx;
    sa  = (a  >= 128) ? a  - 256 : a;
    sn  = (nn >= 128) ? nn - 256 : nn;
    if (sub) begin
      full = a - nn;
      co   = (a >= nn);
      r    = sa - sn;
    end else begin
      full = a + nn;
      co   = (full > 255);
      r    = sa + sn;
    end
    f   = full & 255;
    ovf = (r > 127) || (r < -128);
  endtask

  // Called just after a negedge. It drives one cycle, advances the model
  // across the posedge, then checks the outputs at the following negedge.
  task automatic step(input bit v, input bit [1:0] o, input bit [7:0] xx, input bit [7:0] nn,
                      input bit c, input bit ordy);
    int ef;
    bit eco, eovf, rdy, acc_ok;
    bus0.in_valid = v;  bus0.op = o;  bus0.x = xx;  bus0.n = nn;
    bus0.clr = c;       bus0.out_ready = ordy;
    #1;
    rdy = !m_vld || ordy;
    chk("in_ready", bus0.in_ready, rdy);
    acc_ok = v && rdy;
    @(posedge clk);
    if (acc_ok) begin
      model_calc(o, xx, nn, c, ef, eco, eovf);
      m_f = ef;  m_co = eco;  m_ovf = eovf;  m_vld = 1'b1;
      if (o == 3)    m_acc = ef;
      else if (c)    m_acc = 0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      if (ordy) m_vld = 1'b0;
      if (c)    m_acc = 0;
    end
    @(negedge clk);
    chk("out_valid", bus0.out_valid, m_vld);
    chk("f",         bus0.f,         m_f);
    chk("co",        bus0.co,        m_co);
    chk("ovf",       bus0.ovf,       m_ovf);
    chk("op_cnt",    bus0.op_cnt,    m_cnt);
  endtask

  // Asserts reset between clock edges, checks the reset values, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_vld = 0; m_f = 0; m_co = 0; m_ovf = 0; m_acc = 0; m_cnt = 0;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_f",         bus0.f,         0);
    chk("rst_co",        bus0.co,        0);
    chk("rst_ovf",       bus0.ovf,       0);
    chk("rst_op_cnt",    bus0.op_cnt,    0);
    chk("rst_op_cnt4",   bus1.op_cnt,    0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.in_valid = 0; bus0.x = 0; bus0.n = 0; bus0.op = 0; bus0.clr = 0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.x = 0; bus1.n = 0; bus1.op = 0; bus1.clr = 0; bus1.out_ready = 1;
    @(negedge clk);
    do_reset();

    // legacy mode
    step(1, 2'b00, 8'h06, 8'h03, 0, 1);
    chk("t1a_f", bus0.f, 8'h09); chk("t1a_co", bus0.co, 0); chk("t1a_ovf", bus0.ovf, 0);
    step(1, 2'b00, 8'h07, 8'h09, 0, 1);
    chk("t1b_f", bus0.f, 8'hFE); chk("t1b_co", bus0.co, 0); chk("t1b_ovf", bus0.ovf, 0);

    // explicit add/sub with carry and overflow corners
    step(1, 2'b01, 8'h7F, 8'h01, 0, 1);
    chk("t2a_f", bus0.f, 8'h80); chk("t2a_co", bus0.co, 0); chk("t2a_ovf", bus0.ovf, 1);
    step(1, 2'b01, 8'hFF, 8'h01, 0, 1);
    chk("t2b_f", bus0.f, 8'h00); chk("t2b_co", bus0.co, 1); chk("t2b_ovf", bus0.ovf, 0);
    step(1, 2'b10, 8'h80, 8'h01, 0, 1);
    chk("t2c_f", bus0.f, 8'h7F); chk("t2c_co", bus0.co, 1); chk("t2c_ovf", bus0.ovf, 1);

    // backpressure
    do_reset();
    step(1, 2'b01, 8'h10, 8'h01, 0, 0);
    step(1, 2'b01, 8'h20, 8'h02, 0, 0);
    chk("t3_in_ready", bus0.in_ready, 0);
    chk("t3_hold_f",   bus0.f,        8'h11);
    step(1, 2'b01, 8'h20, 8'h02, 0, 0);
    chk("t3_hold_f2",  bus0.f,        8'h11);
    step(1, 2'b01, 8'h20, 8'h02, 0, 1);
    chk("t3_f2",  bus0.f,      8'h22);
    chk("t3_cnt", bus0.op_cnt, 2);
    step(0, 2'b01, 8'h00, 8'h00, 0, 1);
    chk("t3_drained", bus0.out_valid, 0);
    chk("t3_f_holds", bus0.f,         8'h22);

    // accumulate
    step(0, 2'b00, 8'h00, 8'h00, 1, 1);
    step(1, 2'b11, 8'h00, 8'h05, 0, 1);  chk("t4_f1", bus0.f, 8'h05);
    step(1, 2'b11, 8'hF0, 8'h05, 0, 1);  chk("t4_f2", bus0.f, 8'h0A);
    step(1, 2'b11, 8'h00, 8'h05, 0, 1);  chk("t4_f3", bus0.f, 8'h0F);
    step(1, 2'b11, 8'h01, 8'h14, 0, 1);
    chk("t4_sub_f", bus0.f, 8'hFB); chk("t4_sub_co", bus0.co, 0);
    step(1, 2'b11, 8'h00, 8'h04, 1, 1);  chk("t4_clr_f", bus0.f, 8'h04);
    step(1, 2'b11, 8'h00, 8'h00, 0, 1);  chk("t4_acc",   bus0.f, 8'h04);
    // clr alongside a non-accumulate op zeroes acc and lets that op through
    step(1, 2'b01, 8'h30, 8'h03, 1, 1);  chk("t4_clr_add", bus0.f, 8'h33);
    step(1, 2'b11, 8'h00, 8'h00, 0, 1);  chk("t4_acc0",    bus0.f, 8'h00);
    // clr while in_ready=0 still clears acc
    step(1, 2'b11, 8'h00, 8'h09, 0, 0);
    step(1, 2'b01, 8'h00, 8'h00, 1, 0);
    chk("t4_clr_stall_rdy", bus0.in_ready, 0);
    step(1, 2'b11, 8'h00, 8'h00, 0, 1);  chk("t4_clr_stall", bus0.f, 8'h00);

    // streaming with randomised add/sub; dut1 streams alongside to show saturation
    do_reset();
    bus1.in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      step(1, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1);
    end
    chk("t5_cnt10",  bus0.op_cnt, 10);
    chk("t5_cnt4_10", bus1.op_cnt, 10);
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b01, 8'h00, 8'h00, 0, 1);
    end
    chk("t5_cnt4_sat", bus1.op_cnt, 4'hF);
    chk("t5_cnt4_vld", bus1.out_valid, 1);
    bus1.in_valid = 0;

    // random mix over every op, with clr and a random consumer stall
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end

    // reset in mid-operation, with a result pending and acc=0x0F
    step(1, 2'b00, 8'h00, 8'h00, 1, 1);
    step(1, 2'b11, 8'h00, 8'h0F, 0, 1);
    chk("t6_pre_vld", bus0.out_valid, 1);
    chk("t6_pre_f",   bus0.f,         8'h0F);
    do_reset();
    step(1, 2'b11, 8'h00, 8'h01, 0, 1);
    chk("t6_post_f", bus0.f, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
